decode_issue: RTL and testbench

// - Producer end of the alu_ops/io_ops/bj_ops bundles consumed by the execute ALU.
// - Decodes one 32-bit RV64IMA instruction per cycle into one-hot op strobes, operand controls and a

---
 rtl/decode_issue_if.sv | 45 ++++
 rtl/decode_issue.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_decode_issue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// ---------------------------------------------------------------------------
// decode_issue_if.sv
// Handshake bundles around the decode stage.
//
// decode_in_if  : fetch/expander -> decode
//   in_valid, in_inst[31:0], in_pc[XLEN-1:0], in_compressed  (master drives)
//   in_ready                                                  (slave drives)
// decode_out_if : decode -> execute
//   out_valid plus the decoded payload (op strobes, imm, operand controls,
//   register indices, pc, compressed flag, illegal flag)      (master drives)
//   out_ready                                                 (slave drives)
// ---------------------------------------------------------------------------
interface decode_in_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            in_compressed;

    modport master (output in_valid, in_inst, in_pc, in_compressed, input in_ready);
    modport slave  (input in_valid, in_inst, in_pc, in_compressed, output in_ready);
endinterface

interface decode_out_if #(parameter int XLEN = 64);
    logic            out_valid;
    logic            out_ready;
    logic [17:0]     out_alu_ops;
    logic [7:0]      out_bj_ops;
    logic [10:0]     out_io_ops;
    logic [XLEN-1:0] out_imm;
    logic            out_with_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_pc;
    logic            out_compressed;
    logic            out_illegal;

    modport master (output out_valid, out_alu_ops, out_bj_ops, out_io_ops, out_imm,
                    out_with_imm, out_rs1, out_rs2, out_rd, out_pc, out_compressed,
                    out_illegal, input out_ready);
    modport slave  (input out_valid, out_alu_ops, out_bj_ops, out_io_ops, out_imm,
                    out_with_imm, out_rs1, out_rs2, out_rd, out_pc, out_compressed,
                    out_illegal, output out_ready);
endinterface

// File: rtl/decode_issue.sv
// ---------------------------------------------------------------------------
// decode_issue.sv
// Decodes one RV64IMA instruction per cycle into one-hot op strobes, operand
// controls and a sign-extended immediate, and registers the result into the
// decode->execute pipeline register (latency 1).
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : kills the held payload and any instruction offered this cycle
//   in_if      : decode_in_if.slave   (instruction from fetch/expander)
//   out_if     : decode_out_if.master (decoded payload to execute)
//
// Build option
//   DECODE_SKID_EN : adds a second (skid) entry so in_ready comes straight
//                    from a flop instead of combinationally from out_ready.
// ---------------------------------------------------------------------------
module decode_issue #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    decode_in_if.slave   in_if,
    decode_out_if.master out_if
);
    // alu_ops / bj_ops / io_ops bit positions
    localparam int ADD = 0, SUB = 1, SLT = 2, AND_ = 3, OR_ = 4, XOR_ = 5, SLL = 6, SRL = 7,
                   SRA = 8, LUI = 9, AUIPC = 10, MUL = 11, MULH = 12, MULHSU = 13, DIV = 14,
                   REM = 15, UNS = 16, WORD = 17;
    localparam int BEQ = 0, BNE = 1, BLT = 2, BGE = 3, BLTU = 4, BGEU = 5, JAL = 6, JALR = 7;
    localparam int A_ADD = 0, A_MIN = 1, A_MAX = 2, A_MINU = 3, A_MAXU = 4, A_XOR = 5,
                   A_OR = 6, A_AND = 7, A_SWAP = 8, LOAD = 9, STORE = 10;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OPIMM32 = 7'b0011011,
                           OPC_OP = 7'b0110011, OPC_OP32 = 7'b0111011, OPC_AMO = 7'b0101111;

    typedef struct packed {
        logic [17:0]     alu;
        logic [7:0]      bj;
        logic [10:0]     io;
        logic [XLEN-1:0] imm;
        logic            with_imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            compressed;
        logic            illegal;
    } payload_t;

    logic [31:0]     inst;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;

    assign inst   = in_if.in_inst;
    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_j  = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
    assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};

    logic [17:0]     alu;
    logic [7:0]      bj;
    logic [10:0]     io;
    logic [XLEN-1:0] imm;
    logic            with_imm, use_rs1, use_rs2, use_rd, illegal;
    payload_t        dec;

    always_comb begin
        alu = '0; bj = '0; io = '0; imm = '0;
        with_imm = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opc)
                OPC_LUI:   begin alu[LUI] = 1'b1; imm = imm_u; with_imm = 1'b1; use_rd = 1'b1; end
                OPC_AUIPC: begin alu[AUIPC] = 1'b1; imm = imm_u; with_imm = 1'b1; use_rd = 1'b1; end
                OPC_JAL:   begin bj[JAL] = 1'b1; imm = imm_j; with_imm = 1'b1; use_rd = 1'b1; end
                OPC_JALR: begin
                    bj[JALR] = 1'b1; imm = imm_i; with_imm = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                    illegal = (f3 != 3'd0);
                end
                OPC_BRANCH: begin
                    imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    case (f3)
                        3'd0: bj[BEQ] = 1'b1;
                        3'd1: bj[BNE] = 1'b1;
                        3'd4: bj[BLT] = 1'b1;
                        3'd5: bj[BGE] = 1'b1;
                        3'd6: begin bj[BLTU] = 1'b1; alu[UNS] = 1'b1; end
                        3'd7: begin bj[BGEU] = 1'b1; alu[UNS] = 1'b1; end
                        default: illegal = 1'b1;
                    endcase
                end
                // Loads/stores reuse the adder for the address; io bit tells execute which.
                OPC_LOAD: begin
                    alu[ADD] = 1'b1; io[LOAD] = 1'b1; imm = imm_i; with_imm = 1'b1;
                    use_rs1 = 1'b1; use_rd = 1'b1; illegal = (f3 == 3'd7);
                end
                OPC_STORE: begin
                    alu[ADD] = 1'b1; io[STORE] = 1'b1; imm = imm_s; with_imm = 1'b1;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; illegal = f3[2];
                end
                OPC_OPIMM, OPC_OPIMM32: begin
                    imm = imm_i; with_imm = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                    alu[WORD] = (opc == OPC_OPIMM32);
                    case (f3)
                        3'd0: alu[ADD] = 1'b1;
                        3'd1: begin
                            alu[SLL] = 1'b1;
                            imm = alu[WORD] ? shamt5 : shamt6;
                            illegal = alu[WORD] ? (f7 != 7'h00) : (inst[31:26] != 6'h00);
                        end
                        3'd5: begin
                            alu[SRL] = ~inst[30]; alu[SRA] = inst[30];
                            imm = alu[WORD] ? shamt5 : shamt6;
                            illegal = alu[WORD] ? ({f7[6], f7[4:0]} != 6'h00)
                                                : ({inst[31], inst[29:26]} != 5'h00);
                        end
                        3'd2: begin alu[SLT] = 1'b1; illegal = alu[WORD]; end
                        3'd3: begin alu[SLT] = 1'b1; alu[UNS] = 1'b1; illegal = alu[WORD]; end
                        3'd4: begin alu[XOR_] = 1'b1; illegal = alu[WORD]; end
                        3'd6: begin alu[OR_] = 1'b1; illegal = alu[WORD]; end
                        default: begin alu[AND_] = 1'b1; illegal = alu[WORD]; end
                    endcase
                end
                OPC_OP, OPC_OP32: begin
                    use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                    alu[WORD] = (opc == OPC_OP32);
                    case ({f7, f3})
                        {7'h00, 3'd0}: alu[ADD] = 1'b1;
                        {7'h20, 3'd0}: alu[SUB] = 1'b1;
                        {7'h00, 3'd1}: alu[SLL] = 1'b1;
                        {7'h00, 3'd5}: alu[SRL] = 1'b1;
                        {7'h20, 3'd5}: alu[SRA] = 1'b1;
                        {7'h01, 3'd0}: alu[MUL] = 1'b1;
                        {7'h01, 3'd4}: alu[DIV] = 1'b1;
                        {7'h01, 3'd5}: begin alu[DIV] = 1'b1; alu[UNS] = 1'b1; end
                        {7'h01, 3'd6}: alu[REM] = 1'b1;
                        {7'h01, 3'd7}: begin alu[REM] = 1'b1; alu[UNS] = 1'b1; end
                        // The remaining encodings have no *W form.
                        {7'h00, 3'd2}: begin alu[SLT] = 1'b1; illegal = alu[WORD]; end
                        {7'h00, 3'd3}: begin alu[SLT] = 1'b1; alu[UNS] = 1'b1; illegal = alu[WORD]; end
                        {7'h00, 3'd4}: begin alu[XOR_] = 1'b1; illegal = alu[WORD]; end
                        {7'h00, 3'd6}: begin alu[OR_] = 1'b1; illegal = alu[WORD]; end
                        {7'h00, 3'd7}: begin alu[AND_] = 1'b1; illegal = alu[WORD]; end
                        {7'h01, 3'd1}: begin alu[MULH] = 1'b1; illegal = alu[WORD]; end
                        {7'h01, 3'd2}: begin alu[MULHSU] = 1'b1; illegal = alu[WORD]; end
                        {7'h01, 3'd3}: begin alu[MULH] = 1'b1; alu[UNS] = 1'b1; illegal = alu[WORD]; end
                        default: illegal = 1'b1;
                    endcase
                end
                // LR/SC (funct5 00010/00011) are not handled here and fall into default.
                OPC_AMO: begin
                    use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                    alu[WORD] = (f3 == 3'd2);
                    illegal = (f3 != 3'd2) && (f3 != 3'd3);
                    case (inst[31:27])
                        5'b00000: io[A_ADD]  = 1'b1;
                        5'b00001: io[A_SWAP] = 1'b1;
                        5'b00100: io[A_XOR]  = 1'b1;
                        5'b01000: io[A_OR]   = 1'b1;
                        5'b01100: io[A_AND]  = 1'b1;
                        5'b10000: io[A_MIN]  = 1'b1;
                        5'b10100: io[A_MAX]  = 1'b1;
                        5'b11000: io[A_MINU] = 1'b1;
                        5'b11100: io[A_MAXU] = 1'b1;
                        default:  illegal = 1'b1;
                    endcase
                end
                default: illegal = 1'b1;
            endcase
        end
        // An illegal instruction carries no operation, operands or immediate.
        if (illegal) begin
            alu = '0; bj = '0; io = '0; imm = '0;
            with_imm = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
        end
        dec.alu        = alu;
        dec.bj         = bj;
        dec.io         = io;
        dec.imm        = imm;
        dec.with_imm   = with_imm;
        dec.rs1        = use_rs1 ? inst[19:15] : 5'd0;
        dec.rs2        = use_rs2 ? inst[24:20] : 5'd0;
        dec.rd         = use_rd ? inst[11:7] : 5'd0;
        dec.pc         = in_if.in_pc;
        dec.compressed = in_if.in_compressed;
        dec.illegal    = illegal;
    end

    // ---------------- pipeline register(s) ----------------
    logic     out_valid_q, out_valid_d;
    payload_t out_q, out_d;
    logic     in_ready, accept, pop;

    assign accept = in_if.in_valid & in_ready & ~flush;
    assign pop    = out_valid_q & out_if.out_ready;

`ifdef DECODE_SKID_EN
    logic     skid_valid_q, skid_valid_d;
    payload_t skid_q, skid_d;

    // Registered ready: while the skid entry is free one more instruction can
    // always be absorbed, even if execute stalls in the same cycle.
    assign in_ready = ~skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign in_ready = ~out_valid_q | out_if.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign in_if.in_ready        = in_ready;
    assign out_if.out_valid      = out_valid_q;
    assign out_if.out_alu_ops    = out_q.alu;
    assign out_if.out_bj_ops     = out_q.bj;
    assign out_if.out_io_ops     = out_q.io;
    assign out_if.out_imm        = out_q.imm;
    assign out_if.out_with_imm   = out_q.with_imm;
    assign out_if.out_rs1        = out_q.rs1;
    assign out_if.out_rs2        = out_q.rs2;
    assign out_if.out_rd         = out_q.rd;
    assign out_if.out_pc         = out_q.pc;
    assign out_if.out_compressed = out_q.compressed;
    assign out_if.out_illegal    = out_q.illegal;
endmodule

// File: tb/tb_decode_issue.sv
// ---------------------------------------------------------------------------
// tb_decode_issue.sv
// Table of instruction vectors with hand-derived expected decode results;
// expected payloads are queued when an instruction is accepted and compared
// when execute consumes the output. Extra sequences cover back-pressure,
// flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_decode_issue;
    localparam int XLEN = 64;
    localparam int PW   = 183;   // payload width: 18+8+11+64+1+15+64+1+1

    localparam logic [17:0] A_ADD = 18'd1 << 0,  A_SUB = 18'd1 << 1,  A_SLT = 18'd1 << 2,
                            A_SRA = 18'd1 << 8,  A_LUI = 18'd1 << 9,  A_AUIPC = 18'd1 << 10,
                            A_MULH = 18'd1 << 12, A_DIV = 18'd1 << 14, A_UNS = 18'd1 << 16,
                            A_WORD = 18'd1 << 17;
    localparam logic [7:0]  B_BGE = 8'd1 << 3, B_BLTU = 8'd1 << 4, B_JAL = 8'd1 << 6,
                            B_JALR = 8'd1 << 7;
    localparam logic [10:0] IO_AADD = 11'd1 << 0, IO_AMAXU = 11'd1 << 4, IO_LOAD = 11'd1 << 9,
                            IO_STORE = 11'd1 << 10;

    typedef struct packed {
        logic [31:0] inst;
        logic        comp;
        logic [17:0] alu;
        logic [7:0]  bj;
        logic [10:0] io;
        logic [63:0] imm;
        logic        wimm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    localparam int NV = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    decode_in_if  #(.XLEN(XLEN)) in_if ();
    decode_out_if #(.XLEN(XLEN)) out_if ();

    decode_issue #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .in_if  (in_if),
        .out_if (out_if)
    );

    always #5 clk = ~clk;

    vec_t          vecs [NV];
    logic [PW-1:0] sb_q [$];
    logic [PW-1:0] exp_cur;
    logic [PW-1:0] stall_snap;
    logic          stall_prev = 1'b0;
    logic          last_acc = 1'b0;
    int            stall_left = 0;
    int            checks = 0;
    int            errors = 0;
    int            n_out = 0;

    function automatic vec_t mkv(input logic [31:0] inst, input logic comp, input logic [17:0] alu,
                                 input logic [7:0] bj, input logic [10:0] io, input logic [63:0] imm,
                                 input logic wimm, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic ill);
        vec_t v;
        v.inst = inst; v.comp = comp; v.alu = alu; v.bj = bj; v.io = io; v.imm = imm;
        v.wimm = wimm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    function automatic logic [PW-1:0] exp_of(input vec_t v, input logic [63:0] pc);
        return {v.alu, v.bj, v.io, v.imm, v.wimm, v.rs1, v.rs2, v.rd, pc, v.comp, v.ill};
    endfunction

    function automatic logic [PW-1:0] act_payload();
        return {out_if.out_alu_ops, out_if.out_bj_ops, out_if.out_io_ops, out_if.out_imm,
                out_if.out_with_imm, out_if.out_rs1, out_if.out_rs2, out_if.out_rd,
                out_if.out_pc, out_if.out_compressed, out_if.out_illegal};
    endfunction

    function automatic void check(input string name, input logic [PW:0] act, input logic [PW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [PW:0] bit1(input logic b);
        return {{PW{1'b0}}, b};
    endfunction

    // One clock: called at a falling edge with inputs already driven; samples
    // the handshake that the next rising edge will perform, then waits for the
    // following falling edge.
    task automatic cycle();
        logic [PW-1:0] exp_p;
        out_if.out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
        if (stall_prev)
            check("stall_stable", {out_if.out_valid, act_payload()}, {1'b1, stall_snap});
        stall_prev = out_if.out_valid && !out_if.out_ready && !flush;
        stall_snap = act_payload();
        if (out_if.out_valid && out_if.out_ready && !flush) begin
            n_out++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", act_payload());
            end else begin
                exp_p = sb_q.pop_front();
                check("payload", {1'b1, act_payload()}, {1'b1, exp_p});
                $display("txn pc=%h alu=%h bj=%h io=%h imm=%h rd=%0d ill=%0d", out_if.out_pc,
                         out_if.out_alu_ops, out_if.out_bj_ops, out_if.out_io_ops,
                         out_if.out_imm, out_if.out_rd, out_if.out_illegal);
            end
        end
        if (flush) sb_q.delete();
        last_acc = in_if.in_valid && in_if.in_ready && !flush;
        if (last_acc) sb_q.push_back(exp_cur);
        @(negedge clk);
    endtask

    task automatic send(input vec_t v, input logic [63:0] pc);
        in_if.in_valid      = 1'b1;
        in_if.in_inst       = v.inst;
        in_if.in_pc         = pc;
        in_if.in_compressed = v.comp;
        exp_cur             = exp_of(v, pc);
        last_acc            = 1'b0;
        for (int t = 0; t < 50 && !last_acc; t++) cycle();
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1 pc=%h", pc);
        end
        in_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        stall_left = 0;
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) cycle();
        check("drain_empty", bit1(sb_q.size() == 0), bit1(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        vecs[0]  = mkv(32'hfff30293, 1'b0, A_ADD, 0, 0, 64'hffff_ffff_ffff_ffff, 1, 6, 0, 5, 0);
        vecs[1]  = mkv(32'h0020e463, 1'b0, A_UNS, B_BLTU, 0, 64'd8, 0, 1, 2, 0, 0);
        vecs[2]  = mkv(32'h003100bb, 1'b0, A_ADD | A_WORD, 0, 0, 64'd0, 0, 2, 3, 1, 0);
        vecs[3]  = mkv(32'h023130b3, 1'b0, A_MULH | A_UNS, 0, 0, 64'd0, 0, 2, 3, 1, 0);
        vecs[4]  = mkv(32'h403100b3, 1'b0, A_SUB, 0, 0, 64'd0, 0, 2, 3, 1, 0);
        vecs[5]  = mkv(32'h123453b7, 1'b0, A_LUI, 0, 0, 64'h1234_5000, 1, 0, 0, 7, 0);
        vecs[6]  = mkv(32'h800003b7, 1'b0, A_LUI, 0, 0, 64'hffff_ffff_8000_0000, 1, 0, 0, 7, 0);
        vecs[7]  = mkv(32'hffc12503, 1'b0, A_ADD, 0, IO_LOAD, 64'hffff_ffff_ffff_fffc, 1, 2, 0, 10, 0);
        vecs[8]  = mkv(32'h00513823, 1'b0, A_ADD, 0, IO_STORE, 64'd16, 1, 2, 5, 0, 0);
        vecs[9]  = mkv(32'h43f15093, 1'b0, A_SRA, 0, 0, 64'd63, 1, 2, 0, 1, 0);
        vecs[10] = mkv(32'h40011093, 1'b0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1);
        vecs[11] = mkv(32'h00513093, 1'b0, A_SLT | A_UNS, 0, 0, 64'd5, 1, 2, 0, 1, 0);
        vecs[12] = mkv(32'h001000ef, 1'b0, 0, B_JAL, 0, 64'h800, 1, 0, 0, 1, 0);
        vecs[13] = mkv(32'h00008067, 1'b1, 0, B_JALR, 0, 64'd0, 1, 1, 0, 0, 0);
        vecs[14] = mkv(32'h005321af, 1'b0, A_WORD, 0, IO_AADD, 64'd0, 0, 6, 5, 3, 0);
        vecs[15] = mkv(32'he05331af, 1'b0, 0, 0, IO_AMAXU, 64'd0, 0, 6, 5, 3, 0);
        vecs[16] = mkv(32'h100321af, 1'b0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1);
        vecs[17] = mkv(32'h00000073, 1'b0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1);
        vecs[18] = mkv(32'h023150bb, 1'b0, A_DIV | A_UNS | A_WORD, 0, 0, 64'd0, 0, 2, 3, 1, 0);
        vecs[19] = mkv(32'h00001097, 1'b0, A_AUIPC, 0, 0, 64'h1000, 1, 0, 0, 1, 0);
        vecs[20] = mkv(32'hfe20dee3, 1'b0, 0, B_BGE, 0, 64'hffff_ffff_ffff_fffc, 0, 1, 2, 0, 0);
        vecs[21] = mkv(32'h00000000, 1'b0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1);
        vecs[22] = mkv(32'h41f1509b, 1'b0, A_SRA | A_WORD, 0, 0, 64'd31, 1, 2, 0, 1, 0);
        vecs[23] = mkv(32'h0201109b, 1'b0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1);

        in_if.in_valid = 1'b0; in_if.in_inst = '0; in_if.in_pc = '0; in_if.in_compressed = 1'b0;
        out_if.out_ready = 1'b0;

        // Reset state
        #2;
        check("reset_outputs", {out_if.out_valid, act_payload()}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", bit1(in_if.in_ready), bit1(1'b1));
        @(negedge clk);

        // Decode table, streaming with occasional short stalls
        for (int i = 0; i < NV; i++) begin
            if (i % 5 == 3) stall_left = $urandom_range(1, 2);
            send(vecs[i], 64'h1000 + 64'(4 * i));
        end
        drain();

        // Back-pressure: 8 back-to-back instructions, execute stalls 5 cycles
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i], 64'h2000 + 64'(4 * i));
            if (i == 1) stall_left = 5;
        end
        drain();
        check("bp_delivered", bit1(1'b0) | (PW+1)'(n_out - n0), (PW+1)'(8));

        // Flush while output stalled and a new instruction offered
        stall_left = 3;
        send(vecs[2], 64'h3000);
        in_if.in_valid = 1'b1; in_if.in_inst = vecs[3].inst; in_if.in_pc = 64'h3004;
        exp_cur = exp_of(vecs[3], 64'h3004);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_if.in_valid = 1'b0;
        check("flush_stalled_valid", bit1(out_if.out_valid), bit1(1'b0));
        stall_left = 0;
        n0 = n_out;
        repeat (3) cycle();
        send(vecs[4], 64'h3008);
        drain();
        check("flush_only_survivor", (PW+1)'(n_out - n0), (PW+1)'(1));

        // Flush while output is being consumed and input is accepted
        send(vecs[5], 64'h4000);
        in_if.in_valid = 1'b1; in_if.in_inst = vecs[6].inst; in_if.in_pc = 64'h4004;
        exp_cur = exp_of(vecs[6], 64'h4004);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_if.in_valid = 1'b0;
        check("flush_ready_valid", bit1(out_if.out_valid), bit1(1'b0));
        repeat (2) cycle();

        // Asynchronous reset mid-stream
        stall_left = 5;
        send(vecs[0], 64'h5000);
        check("pre_reset_valid", bit1(out_if.out_valid), bit1(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {out_if.out_valid, act_payload()}, '0);
        sb_q.delete();
        stall_prev = 1'b0;
        stall_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_async_reset", bit1(in_if.in_ready), bit1(1'b1));
        @(negedge clk);
        send(vecs[1], 64'h6000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
